// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder: the carry chain is split into STAGES slices, one slice per register stage.
// Optional signed-overflow output ovf is built when ADDER_OVF_FLAG_EN is defined.
module pipelined_adder #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             c_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out
`ifdef ADDER_OVF_FLAG_EN
   ,
   output logic             ovf
`endif
);

   localparam int SAFE_STAGES = (STAGES < 1) ? 1 : STAGES;
   localparam int SW          = WIDTH / SAFE_STAGES;

   generate
      if ((STAGES < 1) || ((WIDTH % SAFE_STAGES) != 0)) begin : g_bad_cfg
         $error("pipelined_adder: WIDTH must be a multiple of STAGES and STAGES >= 1");
      end
   endgenerate

   // Handshake: a transfer happens on a rising edge where valid && ready.
   // Every stage advances together on en; in_ready is en itself, so a stalled
   // output freezes the whole pipe and an empty output slot never blocks.
   logic                  en;
   logic [SAFE_STAGES-1:0] st_v;
   logic [SAFE_STAGES-1:0] st_c;
   logic [WIDTH-1:0]      st_sum [SAFE_STAGES];
   logic [WIDTH-1:0]      st_x   [SAFE_STAGES];
   logic [WIDTH-1:0]      st_y   [SAFE_STAGES];
   logic [WIDTH-1:0]      nxt_sum [SAFE_STAGES];
   logic [SAFE_STAGES-1:0] nxt_c;
   logic [WIDTH:0]        slice_res;
`ifdef ADDER_OVF_FLAG_EN
   logic                  top_a_msb;
   logic                  top_b_msb;
`endif

   // Adds slice k of a and b plus ci, writes it into part; result is {carry, part}.
   function automatic logic [WIDTH:0] add_slice(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic [WIDTH-1:0] part,
                                                input logic             ci,
                                                input int               k);
      logic [SW:0]      t;
      logic [WIDTH-1:0] r;
      t = {1'b0, a[k*SW +: SW]} + {1'b0, b[k*SW +: SW]} + {{SW{1'b0}}, ci};
      r = part;
      r[k*SW +: SW] = t[SW-1:0];
      return {t[SW], r};
   endfunction

   assign en        = !st_v[SAFE_STAGES-1] || out_ready;
   assign in_ready  = en;
   assign out_valid = st_v[SAFE_STAGES-1];
   assign sum       = st_sum[SAFE_STAGES-1];
   assign c_out     = st_c[SAFE_STAGES-1];

   always_comb begin
      nxt_sum   = '{default: '0};
      nxt_c     = '0;
      slice_res = add_slice(x, y, '0, c_in, 0);
      nxt_sum[0] = slice_res[WIDTH-1:0];
      nxt_c[0]   = slice_res[WIDTH];
`ifdef ADDER_OVF_FLAG_EN
      top_a_msb = x[WIDTH-1];
      top_b_msb = y[WIDTH-1];
`endif
      for (int k = 1; k < SAFE_STAGES; k++) begin
         slice_res  = add_slice(st_x[k-1], st_y[k-1], st_sum[k-1], st_c[k-1], k);
         nxt_sum[k] = slice_res[WIDTH-1:0];
         nxt_c[k]   = slice_res[WIDTH];
`ifdef ADDER_OVF_FLAG_EN
         // Operand MSBs feeding the last stage; the loop leaves the top stage's values.
         top_a_msb = st_x[k-1][WIDTH-1];
         top_b_msb = st_y[k-1][WIDTH-1];
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_v <= '0;
         st_c <= '0;
         for (int k = 0; k < SAFE_STAGES; k++) begin
            st_sum[k] <= '0;
            st_x[k]   <= '0;
            st_y[k]   <= '0;
         end
`ifdef ADDER_OVF_FLAG_EN
         ovf <= 1'b0;
`endif
      end else if (en) begin
         st_v[0] <= in_valid;
         st_x[0] <= x;
         st_y[0] <= y;
         st_c    <= nxt_c;
         for (int k = 0; k < SAFE_STAGES; k++) begin
            st_sum[k] <= nxt_sum[k];
         end
         for (int k = 1; k < SAFE_STAGES; k++) begin
            st_v[k] <= st_v[k-1];
            st_x[k] <= st_x[k-1];
            st_y[k] <= st_y[k-1];
         end
`ifdef ADDER_OVF_FLAG_EN
         // Carry into the MSB is a^b^s at that bit; overflow is it XOR carry out.
         ovf <= top_a_msb ^ top_b_msb ^ nxt_sum[SAFE_STAGES-1][WIDTH-1] ^ nxt_c[SAFE_STAGES-1];
`endif
      end
   end

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder (WIDTH=32, STAGES=4); covers ovf when ADDER_OVF_FLAG_EN is defined.
module tb_pipelined_adder;

   localparam int W = 32;
   localparam int S = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] x;
   logic [W-1:0] y;
   logic         c_in;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         c_out;
`ifdef ADDER_OVF_FLAG_EN
   logic         ovf;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   logic [W:0] exp_q[$];

   logic         obs_in_ready;
   logic         obs_out_valid;
   logic [W-1:0] obs_sum;
   logic         obs_c;
   logic         obs_ovf;
   logic         obs_acc;
   logic         obs_dlv;

   pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .y         (y),
      .c_in      (c_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .c_out     (c_out)
`ifdef ADDER_OVF_FLAG_EN
      ,
      .ovf       (ovf)
`endif
   );

   always #5 clk = ~clk;

   // Reference: plain (W+1)-bit addition, result packed as {carry, sum}.
   function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic ci);
      return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
   endfunction

   // Driver: called just after a falling edge; applies inputs, samples outputs, advances one cycle.
   task automatic drive_cycle(input logic r, input logic v, input logic [W-1:0] xa,
                              input logic [W-1:0] ya, input logic ci, input logic ordy);
      rst       = r;
      in_valid  = v;
      x         = xa;
      y         = ya;
      c_in      = ci;
      out_ready = ordy;
      #1;
      obs_in_ready  = in_ready;
      obs_out_valid = out_valid;
      obs_sum       = sum;
      obs_c         = c_out;
`ifdef ADDER_OVF_FLAG_EN
      obs_ovf       = ovf;
`else
      obs_ovf       = 1'b0;
`endif
      obs_acc = v && in_ready && !r;
      obs_dlv = out_valid && ordy && !r;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      drive_cycle(1'b1, 1'b0, '0, '0, 1'b0, 1'b1);
      drive_cycle(1'b1, 1'b1, 32'h1234_5678, 32'h1, 1'b1, 1'b1);
      drive_cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
      n_checks++;
      if (obs_out_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_out_valid: got %b expected 0", obs_out_valid);
      end
      n_checks++;
      if (obs_sum !== '0) begin
         n_fail++; $display("FAIL reset_sum: got %h expected 00000000", obs_sum);
      end
      n_checks++;
      if (obs_c !== 1'b0) begin
         n_fail++; $display("FAIL reset_c_out: got %b expected 0", obs_c);
      end
      n_checks++;
      if (obs_in_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_in_ready: got %b expected 1", obs_in_ready);
      end
`ifdef ADDER_OVF_FLAG_EN
      n_checks++;
      if (obs_ovf !== 1'b0) begin
         n_fail++; $display("FAIL reset_ovf: got %b expected 0", obs_ovf);
      end
`endif
   endtask

   task automatic test_basic();
      int  lat;
      bit  found;
      lat   = 0;
      found = 1'b0;
      drive_cycle(1'b0, 1'b1, 32'h0000_0005, 32'h0000_0003, 1'b0, 1'b1);
      n_checks++;
      if (obs_acc !== 1'b1) begin
         n_fail++; $display("FAIL basic_accept: got %b expected 1", obs_acc);
      end
      for (int i = 1; i <= 20 && !found; i++) begin
         drive_cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
         if (obs_out_valid) begin
            found = 1'b1;
            lat   = i;
            n_checks++;
            if (obs_sum !== 32'h0000_0008) begin
               n_fail++; $display("FAIL basic_sum: got %h expected 00000008", obs_sum);
            end
            n_checks++;
            if (obs_c !== 1'b0) begin
               n_fail++; $display("FAIL basic_c_out: got %b expected 0", obs_c);
            end
         end
      end
      n_checks++;
      if (!found || lat != S) begin
         n_fail++; $display("FAIL basic_latency: got %0d (found=%0b) expected %0d", lat, found, S);
      end
   endtask

   task automatic test_wrap();
      logic [W-1:0] vx [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h00FF_FFFF,
                               32'hFFFF_0000, 32'h1234_5678, 32'h8000_0000};
      logic [W-1:0] vy [6] = '{32'h0000_0000, 32'h0000_0001, 32'h0000_0001,
                               32'h0000_FFFF, 32'h8765_4321, 32'h8000_0000};
      logic         vc [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [W:0]   ve [6] = '{{1'b1, 32'h0000_0000}, {1'b1, 32'h0000_0000},
                               {1'b0, 32'h0100_0000}, {1'b1, 32'h0000_0000},
                               {1'b0, 32'h9999_9999}, {1'b1, 32'h0000_0000}};
      int           sent;
      int           got;
      int           idx;
      logic [W:0]   e;
      sent = 0;
      got  = 0;
      for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
         idx = (sent < 6) ? sent : 5;
         drive_cycle(1'b0, sent < 6, vx[idx], vy[idx], vc[idx], 1'b1);
         if (obs_dlv) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++; $display("FAIL wrap_extra: got %h with no result expected", obs_sum);
            end else begin
               e = exp_q.pop_front();
               if ({obs_c, obs_sum} !== e) begin
                  n_fail++; $display("FAIL wrap_result: got c=%b sum=%h expected c=%b sum=%h",
                                     obs_c, obs_sum, e[W], e[W-1:0]);
               end
            end
            got++;
         end
         if (obs_acc) begin
            exp_q.push_back(ve[sent]);
            sent++;
         end
      end
      n_checks++;
      if (got != 6) begin
         n_fail++; $display("FAIL wrap_count: got %0d results expected 6", got);
      end
      exp_q.delete();
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] cx;
      logic [W-1:0] cy;
      logic         cc;
      int           sent;
      int           got;
      int           drops;
      logic [W:0]   e;
      sent  = 0;
      got   = 0;
      drops = 0;
      cx = $urandom();
      cy = $urandom();
      cc = 1'($urandom_range(0, 1));
      for (int cyc = 0; cyc < 200 && got < 100; cyc++) begin
         drive_cycle(1'b0, sent < 100, cx, cy, cc, 1'b1);
         if (sent < 100 && !obs_in_ready) drops++;
         if (obs_dlv) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++; $display("FAIL b2b_extra: got %h with no result expected", obs_sum);
            end else begin
               e = exp_q.pop_front();
               if ({obs_c, obs_sum} !== e) begin
                  n_fail++; $display("FAIL b2b_result %0d: got c=%b sum=%h expected c=%b sum=%h",
                                     got, obs_c, obs_sum, e[W], e[W-1:0]);
               end
            end
            got++;
         end
         if (obs_acc) begin
            exp_q.push_back(ref_add(cx, cy, cc));
            sent++;
            cx = $urandom();
            cy = $urandom();
            cc = 1'($urandom_range(0, 1));
         end
      end
      n_checks++;
      if (drops != 0) begin
         n_fail++; $display("FAIL b2b_in_ready: got %0d cycles low expected 0", drops);
      end
      n_checks++;
      if (got != 100) begin
         n_fail++; $display("FAIL b2b_count: got %0d results expected 100", got);
      end
      exp_q.delete();
   endtask

   task automatic test_stall();
      logic [W-1:0] cx;
      logic [W-1:0] cy;
      logic         cc;
      logic         ordy;
      int           sent;
      int           got;
      int           stall_cnt;
      logic [W-1:0] held_sum;
      logic         held_c;
      logic [W:0]   e;
      sent      = 0;
      got       = 0;
      stall_cnt = 0;
      held_sum  = '0;
      held_c    = 1'b0;
      cx = 32'hF000_0001;
      cy = 32'h1FFF_FFFF;
      cc = 1'b1;
      for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
         ordy = (stall_cnt >= 5);
         drive_cycle(1'b0, sent < 8, cx, cy, cc, ordy);
         if (obs_out_valid && !ordy) begin
            if (stall_cnt == 0) begin
               held_sum = obs_sum;
               held_c   = obs_c;
            end else begin
               n_checks++;
               if (obs_sum !== held_sum || obs_c !== held_c) begin
                  n_fail++; $display("FAIL stall_hold: got c=%b sum=%h expected c=%b sum=%h",
                                     obs_c, obs_sum, held_c, held_sum);
               end
            end
            n_checks++;
            if (obs_in_ready !== 1'b0) begin
               n_fail++; $display("FAIL stall_in_ready: got %b expected 0", obs_in_ready);
            end
            stall_cnt++;
         end
         if (obs_dlv) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++; $display("FAIL stall_extra: got %h with no result expected", obs_sum);
            end else begin
               e = exp_q.pop_front();
               if ({obs_c, obs_sum} !== e) begin
                  n_fail++; $display("FAIL stall_result %0d: got c=%b sum=%h expected c=%b sum=%h",
                                     got, obs_c, obs_sum, e[W], e[W-1:0]);
               end
            end
            got++;
         end
         if (obs_acc) begin
            exp_q.push_back(ref_add(cx, cy, cc));
            sent++;
            cx = cx + 32'h0123_4567;
            cy = cy ^ 32'hA5A5_5A5A;
            cc = ~cc;
         end
      end
      n_checks++;
      if (stall_cnt != 5) begin
         n_fail++; $display("FAIL stall_cycles: got %0d expected 5", stall_cnt);
      end
      n_checks++;
      if (got != 8 || exp_q.size() != 0) begin
         n_fail++; $display("FAIL stall_count: got %0d results (%0d left) expected 8 (0 left)",
                            got, exp_q.size());
      end
      exp_q.delete();
   endtask

   task automatic test_reset_midflight();
      int stale;
      stale = 0;
      for (int i = 0; i < 3; i++) begin
         drive_cycle(1'b0, 1'b1, 32'h1111_1111 * (i + 1), 32'h0000_0100, 1'b0, 1'b1);
         n_checks++;
         if (obs_acc !== 1'b1) begin
            n_fail++; $display("FAIL midrst_accept %0d: got %b expected 1", i, obs_acc);
         end
      end
      drive_cycle(1'b1, 1'b1, 32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b1);
      drive_cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
      n_checks++;
      if (obs_out_valid !== 1'b0) begin
         n_fail++; $display("FAIL midrst_out_valid: got %b expected 0", obs_out_valid);
      end
      n_checks++;
      if (obs_sum !== '0 || obs_c !== 1'b0) begin
         n_fail++; $display("FAIL midrst_outputs: got c=%b sum=%h expected c=0 sum=00000000",
                            obs_c, obs_sum);
      end
      n_checks++;
      if (obs_in_ready !== 1'b1) begin
         n_fail++; $display("FAIL midrst_in_ready: got %b expected 1", obs_in_ready);
      end
      for (int i = 0; i < 10; i++) begin
         drive_cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
         if (obs_out_valid) stale++;
      end
      n_checks++;
      if (stale != 0) begin
         n_fail++; $display("FAIL midrst_stale: got %0d stale results expected 0", stale);
      end
   endtask

`ifdef ADDER_OVF_FLAG_EN
   task automatic test_ovf();
      logic [W-1:0] vx [4] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
      logic [W-1:0] vy [4] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF};
      logic [W-1:0] es [4] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE};
      logic         ec [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      logic         eo [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
      bit           found;
      for (int v = 0; v < 4; v++) begin
         found = 1'b0;
         drive_cycle(1'b0, 1'b1, vx[v], vy[v], 1'b0, 1'b1);
         for (int i = 0; i < 20 && !found; i++) begin
            drive_cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
            if (obs_out_valid) begin
               found = 1'b1;
               n_checks++;
               if (obs_ovf !== eo[v] || obs_c !== ec[v] || obs_sum !== es[v]) begin
                  n_fail++; $display("FAIL ovf_vec %0d: got ovf=%b c=%b sum=%h expected ovf=%b c=%b sum=%h",
                                     v, obs_ovf, obs_c, obs_sum, eo[v], ec[v], es[v]);
               end
            end
         end
         n_checks++;
         if (!found) begin
            n_fail++; $display("FAIL ovf_timeout %0d: got no result expected one", v);
         end
      end
   endtask
`endif

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      x         = '0;
      y         = '0;
      c_in      = 1'b0;
      out_ready = 1'b1;
      test_reset();
      test_basic();
      test_wrap();
      test_back_to_back();
      test_stall();
      test_reset_midflight();
`ifdef ADDER_OVF_FLAG_EN
      test_ovf();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
